// File: rtl/uart_frame_decoder.sv
// Reassembles the 10-byte blackjack status/card frame from the UART RX FIFO and
// publishes the remote flags and dealer cards only when a complete, in-order frame arrives.
module uart_frame_decoder #(
    parameter int N_CARDS        = 9,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_empty,
    input  logic [7:0]             r_data,
    output logic                   rd_uart,
    output logic                   remote_start,
    output logic                   remote_deal,
    output logic                   remote_dealer_finished,
    output logic [4*N_CARDS-1:0]   dealer_cards,
    output logic                   frame_valid,
    output logic                   frame_error,
    output logic [7:0]             error_count
);

    localparam int             TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0]     LAST_IDX  = 4'(N_CARDS);
    localparam logic [TW-1:0]  TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {HUNT = 1'b0, COLLECT = 1'b1} state_t;

    state_t        state_reg;
    logic          rd_uart_reg;
    logic [7:0]    byte_reg;
    logic          byte_vld_reg;
    logic [3:0]    expected_reg;
    logic [2:0]    flags_shadow_reg;
    logic [TW-1:0] timer_reg;
    logic          commit_reg;
    logic          abort_reg;
    logic [2:0]    flags_out_reg;
    logic          frame_valid_reg;
    logic          frame_error_reg;
    logic [7:0]    error_count_reg;

    logic [3:0] idx;
    logic [3:0] val;
    logic       is_status;
    logic       card_ok;
    logic       timeout_hit;

    assign idx       = byte_reg[3:0];
    assign val       = byte_reg[7:4];
    assign is_status = (idx == 4'd0) && !byte_reg[7];
    assign card_ok   = (state_reg == COLLECT) && byte_vld_reg && (idx == expected_reg)
                       && (idx != 4'd0) && (idx <= LAST_IDX);
    // A byte being decoded this cycle always beats an expiring timer.
    assign timeout_hit = (state_reg == COLLECT) && !byte_vld_reg && !rd_uart_reg
                         && (timer_reg == TIMER_MAX);

    // Pop at most every other cycle so the FIFO's lagging empty flag never causes an underflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_uart_reg  <= 1'b0;
            byte_vld_reg <= 1'b0;
            byte_reg     <= 8'h00;
        end else begin
            rd_uart_reg  <= !rx_empty && !rd_uart_reg;
            byte_vld_reg <= rd_uart_reg;
            if (rd_uart_reg)
                byte_reg <= r_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= HUNT;
            expected_reg     <= 4'd0;
            flags_shadow_reg <= 3'b000;
            timer_reg        <= '0;
            commit_reg       <= 1'b0;
            abort_reg        <= 1'b0;
        end else begin
            commit_reg <= 1'b0;
            abort_reg  <= 1'b0;

            if (rd_uart_reg || byte_vld_reg || (state_reg == HUNT) || timeout_hit)
                timer_reg <= '0;
            else
                timer_reg <= timer_reg + 1'b1;

            if (byte_vld_reg) begin
                case (state_reg)
                    HUNT: begin
                        if (is_status) begin
                            flags_shadow_reg <= byte_reg[6:4];
                            expected_reg     <= 4'd1;
                            state_reg        <= COLLECT;
                        end
                    end
                    COLLECT: begin
                        if (card_ok) begin
                            expected_reg <= expected_reg + 4'd1;
                            if (idx == LAST_IDX) begin
                                commit_reg <= 1'b1;
                                state_reg  <= HUNT;
                            end
                        end else if (is_status) begin
                            // A fresh status byte aborts the old frame but starts a new one.
                            abort_reg        <= 1'b1;
                            flags_shadow_reg <= byte_reg[6:4];
                            expected_reg     <= 4'd1;
                        end else begin
                            abort_reg <= 1'b1;
                            state_reg <= HUNT;
                        end
                    end
                    default: state_reg <= HUNT;
                endcase
            end else if (timeout_hit) begin
                abort_reg <= 1'b1;
                state_reg <= HUNT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_valid_reg <= 1'b0;
            frame_error_reg <= 1'b0;
            flags_out_reg   <= 3'b000;
            error_count_reg <= 8'd0;
        end else begin
            frame_valid_reg <= commit_reg;
            frame_error_reg <= abort_reg;
            if (commit_reg)
                flags_out_reg <= flags_shadow_reg;
            if (abort_reg && (error_count_reg != 8'hFF))
                error_count_reg <= error_count_reg + 8'd1;
        end
    end

    // Each slot keeps a shadow value; published values move only on commit.
    genvar gi;
    generate
        for (gi = 0; gi < N_CARDS; gi++) begin : g_slot
            logic [3:0] shadow_reg;
            logic [3:0] card_out_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    shadow_reg   <= 4'd0;
                    card_out_reg <= 4'd0;
                end else begin
                    if (card_ok && (expected_reg == 4'(gi + 1)))
                        shadow_reg <= val;
                    if (commit_reg)
                        card_out_reg <= shadow_reg;
                end
            end
            assign dealer_cards[4*gi +: 4] = card_out_reg;
        end
    endgenerate

    assign rd_uart                = rd_uart_reg;
    assign remote_start           = flags_out_reg[2];
    assign remote_deal            = flags_out_reg[1];
    assign remote_dealer_finished = flags_out_reg[0];
    assign frame_valid            = frame_valid_reg;
    assign frame_error            = frame_error_reg;
    assign error_count            = error_count_reg;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Bench for uart_frame_decoder: FIFO model feeds bytes, a scoreboard matches every
// frame_valid / frame_error pulse against events queued when the stimulus was pushed.
module tb_uart_frame_decoder;

    localparam int N  = 9;
    localparam int TO = 20;

    typedef struct {
        logic        err;
        logic [2:0]  flags;
        logic [35:0] cards;
        logic [7:0]  ecount;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_empty = 1'b1;
    logic [7:0]  r_data = 8'hEE;
    logic        rd_uart;
    logic        remote_start;
    logic        remote_deal;
    logic        remote_dealer_finished;
    logic [35:0] dealer_cards;
    logic        frame_valid;
    logic        frame_error;
    logic [7:0]  error_count;

    int errors = 0;
    int checks = 0;

    logic [7:0] fifo_q[$];
    ev_t        exp_q[$];
    ev_t        e;
    bit         pop_pending = 1'b0;
    int         pop_count = 0;
    int         b2b_count = 0;
    int         underflow_count = 0;
    int         cyc = 0;
    int         last_pop_cyc = 0;
    int         last_err_cyc = 0;

    logic [2:0]  model_flags  = 3'b000;
    logic [35:0] model_cards  = 36'h0;
    logic [7:0]  model_ecount = 8'd0;

    uart_frame_decoder #(.N_CARDS(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .rx_empty               (rx_empty),
        .r_data                 (r_data),
        .rd_uart                (rd_uart),
        .remote_start           (remote_start),
        .remote_deal            (remote_deal),
        .remote_dealer_finished (remote_dealer_finished),
        .dealer_cards           (dealer_cards),
        .frame_valid            (frame_valid),
        .frame_error            (frame_error),
        .error_count            (error_count)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor plus FIFO model; rd_uart seen at a negedge is the pop at the next posedge.
    always @(negedge clk) begin
        cyc++;
        if (!rst && (frame_valid || frame_error)) begin
            if (frame_error)
                last_err_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: unexpected event valid=%0b error=%0b at cycle %0d",
                         frame_valid, frame_error, cyc);
            end else begin
                e = exp_q.pop_front();
                if (frame_error !== e.err || frame_valid !== !e.err ||
                    {remote_start, remote_deal, remote_dealer_finished} !== e.flags ||
                    dealer_cards !== e.cards || error_count !== e.ecount) begin
                    errors++;
                    $display("FAIL scoreboard: got err=%0b flags=%b cards=%h ecount=%0d, expected err=%0b flags=%b cards=%h ecount=%0d",
                             frame_error, {remote_start, remote_deal, remote_dealer_finished},
                             dealer_cards, error_count, e.err, e.flags, e.cards, e.ecount);
                end
            end
        end
        if (pop_pending) begin
            if (fifo_q.size() == 0)
                underflow_count++;
            else
                void'(fifo_q.pop_front());
            pop_count++;
            last_pop_cyc = cyc;
        end
        if (rd_uart && pop_pending)
            b2b_count++;
        pop_pending = rd_uart;
        rx_empty    = (fifo_q.size() == 0);
        r_data      = (fifo_q.size() == 0) ? 8'hEE : fifo_q[0];
    end

    task automatic push_byte(input logic [7:0] b);
        fifo_q.push_back(b);
    endtask

    task automatic expect_valid(input logic [2:0] f, input logic [35:0] c);
        model_flags = f;
        model_cards = c;
        exp_q.push_back('{1'b0, f, c, model_ecount});
    endtask

    task automatic expect_error();
        if (model_ecount != 8'hFF)
            model_ecount = model_ecount + 8'd1;
        exp_q.push_back('{1'b1, model_flags, model_cards, model_ecount});
    endtask

    task automatic push_cards(input logic [35:0] c, input int first, input int last);
        for (int k = first; k <= last; k++)
            push_byte({c[4*(k-1) +: 4], 4'(k)});
    endtask

    task automatic send_frame(input logic [2:0] f, input logic [35:0] c);
        push_byte({1'b0, f, 4'h0});
        push_cards(c, 1, N);
        expect_valid(f, c);
    endtask

    task automatic settle(input string name, input int extra);
        int n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        repeat (extra) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || fifo_q.size() != 0) begin
            errors++;
            $display("FAIL %s settle: %0d expected events pending, %0d bytes unread after %0d cycles",
                     name, exp_q.size(), fifo_q.size(), n);
            exp_q.delete();
            fifo_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({rd_uart, remote_start, remote_deal, remote_dealer_finished, frame_valid, frame_error} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, expected 000000",
                     {rd_uart, remote_start, remote_deal, remote_dealer_finished, frame_valid, frame_error});
        end
        checks++;
        if (dealer_cards !== 36'h0 || error_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_data: cards=%h ecount=%0d, expected 0 and 0", dealer_cards, error_count);
        end
    endtask

    task automatic test_clean_frame();
        pop_count = 0;
        b2b_count = 0;
        send_frame(3'b110, 36'hA98765432);
        settle("clean", 8);
        checks++;
        if (pop_count != 10 || b2b_count != 0 || underflow_count != 0) begin
            errors++;
            $display("FAIL clean_pops: pops=%0d b2b=%0d underflow=%0d, expected 10 0 0",
                     pop_count, b2b_count, underflow_count);
        end
        checks++;
        if ({remote_start, remote_deal, remote_dealer_finished} !== 3'b110 || dealer_cards !== 36'hA98765432) begin
            errors++;
            $display("FAIL clean_outputs: flags=%b cards=%h, expected 110 a98765432",
                     {remote_start, remote_deal, remote_dealer_finished}, dealer_cards);
        end
    endtask

    task automatic test_mid_stream_join();
        for (int k = 3; k <= N; k++)
            push_byte({4'(k + 1), 4'(k)});
        send_frame(3'b101, 36'h123456789);
        settle("join", 8);
        checks++;
        if (error_count !== 8'd0 || dealer_cards !== 36'h123456789) begin
            errors++;
            $display("FAIL join_outputs: ecount=%0d cards=%h, expected 0 123456789", error_count, dealer_cards);
        end
    endtask

    task automatic test_skipped_index();
        push_byte(8'h10);
        push_byte(8'h51);
        push_byte(8'h73);
        expect_error();
        settle("skip", 8);
        checks++;
        if (error_count !== 8'd1 || dealer_cards !== 36'h123456789 ||
            {remote_start, remote_deal, remote_dealer_finished} !== 3'b101) begin
            errors++;
            $display("FAIL skip_hold: ecount=%0d cards=%h flags=%b, expected 1 123456789 101",
                     error_count, dealer_cards, {remote_start, remote_deal, remote_dealer_finished});
        end
        send_frame(3'b011, 36'h0F1E2D3C4);
        settle("skip_recover", 8);
        checks++;
        if (dealer_cards !== 36'h0F1E2D3C4) begin
            errors++;
            $display("FAIL skip_recover: cards=%h, expected 0f1e2d3c4", dealer_cards);
        end
    endtask

    task automatic test_timeout();
        int delta;
        push_byte(8'h10);
        push_byte(8'h51);
        expect_error();
        settle("timeout", 4);
        delta = last_err_cyc - last_pop_cyc;
        checks++;
        if (delta < TO || delta > TO + 4) begin
            errors++;
            $display("FAIL timeout_latency: %0d cycles after last pop, expected %0d..%0d", delta, TO, TO + 4);
        end
        push_byte(8'h72);
        settle("timeout_drop", 10);
        checks++;
        if (error_count !== 8'd2) begin
            errors++;
            $display("FAIL timeout_count: ecount=%0d, expected 2", error_count);
        end
    endtask

    task automatic test_restart();
        push_byte(8'h10);
        push_byte(8'h51);
        push_byte(8'h20);
        expect_error();
        push_cards(36'h987654321, 1, N);
        expect_valid(3'b010, 36'h987654321);
        settle("restart", 8);
        checks++;
        if ({remote_start, remote_deal, remote_dealer_finished} !== 3'b010 || error_count !== 8'd3) begin
            errors++;
            $display("FAIL restart_outputs: flags=%b ecount=%0d, expected 010 3",
                     {remote_start, remote_deal, remote_dealer_finished}, error_count);
        end
    endtask

    task automatic test_back_to_back();
        send_frame(3'b100, 36'h111111111);
        push_byte(8'h80);
        push_byte(8'hFF);
        send_frame(3'b001, 36'hFEDCBA987);
        settle("back_to_back", 8);
        checks++;
        if (dealer_cards !== 36'hFEDCBA987 || error_count !== 8'd3) begin
            errors++;
            $display("FAIL b2b_outputs: cards=%h ecount=%0d, expected fedcba987 3", dealer_cards, error_count);
        end
    endtask

    task automatic test_reset_mid_frame();
        push_byte(8'h70);
        push_cards(36'h5A5A5A5A5, 1, 4);
        settle("midreset_pre", 6);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_flags  = 3'b000;
        model_cards  = 36'h0;
        model_ecount = 8'd0;
        @(negedge clk);
        checks++;
        if ({remote_start, remote_deal, remote_dealer_finished} !== 3'b000 ||
            dealer_cards !== 36'h0 || error_count !== 8'd0) begin
            errors++;
            $display("FAIL midreset_clear: flags=%b cards=%h ecount=%0d, expected all 0",
                     {remote_start, remote_deal, remote_dealer_finished}, dealer_cards, error_count);
        end
        push_cards(36'h5A5A5A5A5, 5, N);
        settle("midreset_tail", 10);
        checks++;
        if (dealer_cards !== 36'h0) begin
            errors++;
            $display("FAIL midreset_tail: cards=%h, expected 0", dealer_cards);
        end
        send_frame(3'b111, 36'h246813579);
        settle("midreset_next", 8);
        checks++;
        if (dealer_cards !== 36'h246813579) begin
            errors++;
            $display("FAIL midreset_next: cards=%h, expected 246813579", dealer_cards);
        end
    endtask

    task automatic test_saturation();
        // First zero opens a frame; each further zero restarts it with an error.
        for (int i = 0; i < 258; i++) begin
            push_byte(8'h00);
            if (i > 0)
                expect_error();
        end
        push_byte(8'hFF);
        expect_error();
        settle("saturation", 8);
        checks++;
        if (error_count !== 8'd255) begin
            errors++;
            $display("FAIL saturation: ecount=%0d, expected 255", error_count);
        end
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_mid_stream_join();
        test_skipped_index();
        test_timeout();
        test_restart();
        test_back_to_back();
        test_reset_mid_frame();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_frame_decoder.md
Name: uart_frame_decoder

Overview:
- Receive-side consumer of the blackjack UART link. Pops bytes from the UART RX FIFO and reassembles the 10-byte status/card frame sent by the remote board's encoder.
- Publishes the remote start/deal/dealer_finished flags and the 9 dealer card values to game logic. Outputs update only on complete, in-order frames.
- Frame format: byte 0 = {1'b0, start, deal, dealer_finished, 4'h0}; byte k (1..9) = {card_value[k-1][3:0], k[3:0]}. The low nibble is always the slot index.

Parameters:
- N_CARDS, 9, card slots per frame; frame length is N_CARDS+1 bytes.
- TIMEOUT_CYCLES, 100000, maximum idle clk cycles between bytes inside a frame before abort.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_empty  in  1  RX FIFO empty flag
- r_data  in  8  RX FIFO head byte, valid while rx_empty=0
- rd_uart  out  1  FIFO pop strobe, registered
- remote_start  out  1  decoded start flag
- remote_deal  out  1  decoded deal flag
- remote_dealer_finished  out  1  decoded dealer_finished flag
- dealer_cards  out  4*N_CARDS  card values; slot i in bits [4i+3:4i]
- frame_valid  out  1  one-cycle pulse when outputs are committed
- frame_error  out  1  one-cycle pulse on a dropped or aborted frame
- error_count  out  8  saturating count of frame_error pulses

Behaviour:
- Reset: all outputs 0, state HUNT, shadow registers 0, timeout counter 0.
- Pop handshake: rd_uart_nxt = !rx_empty && !rd_uart. No back-to-back pops, which absorbs the FIFO's one-cycle empty-flag lag. Maximum rate is 1 byte per 2 cycles.
- Byte capture: r_data is sampled on the edge where rd_uart=1 (the FIFO advances on that same edge). Decode happens on the following cycle.
- Decode: idx = byte[3:0], val = byte[7:4].
- HUNT state:
  - Status byte (idx=0, bit7=0): latch bits 6:4 into shadow, set expected=1, go to COLLECT.
  - Any other byte (idx≠0, or bit7=1): drop silently, no error pulse.
- COLLECT state:
  - idx==expected and 1≤idx≤N_CARDS: shadow[idx-1]=val, expected++.
  - If that idx==N_CARDS: commit shadow to all outputs, pulse frame_valid, go to HUNT.
  - idx==0 with bit7=0 (valid status byte): pulse frame_error, restart the frame from this byte (latch flags, expected=1, stay in COLLECT).
  - Any other mismatch (wrong idx, idx>N_CARDS, or bit7=1 on idx=0): pulse frame_error, go to HUNT.
- Commit timing: outputs and frame_valid change on the edge 2 cycles after the edge that popped the last card byte.
- Timeout: counter clears on each pop and increments every cycle in COLLECT. On reaching TIMEOUT_CYCLES: pulse frame_error, go to HUNT. The counter is inactive in HUNT.
- Output holding: published outputs hold their last committed values through errors, timeouts and HUNT. Partial frames never reach the outputs.
- error_count: increments on every frame_error pulse and saturates at 255.
- Simultaneous timeout and decode in the same cycle: the decode wins and the counter clears.
- Reset mid-frame: discards the shadow registers, returns to HUNT and clears all outputs.

Test Plan:
- Clean frame: bytes 0x60,0x21,0x32,0x43,0x54,0x65,0x76,0x87,0x98,0xA9 fed with rx_empty=0 -> rd_uart alternates 1/0 and each byte is popped exactly once. Then frame_valid pulses once, remote_start=1, remote_deal=1, remote_dealer_finished=0, dealer_cards=36'hA98765432.
- Mid-stream join: FIFO starts at byte 0x43 of a frame, followed by a full clean frame -> first partial bytes dropped with no frame_error, the full frame commits, error_count=0.
- Skipped index: 0x10, 0x51, 0x73 (idx 3, expected 2) -> frame_error pulses once, outputs unchanged, error_count=1. A subsequent clean frame commits normally.
- Timeout: 0x10, 0x51, then rx_empty=1 for TIMEOUT_CYCLES (set to 20) -> frame_error at cycle 20, HUNT. A later 0x72 is dropped with no error.
- Restart on status byte: 0x10, 0x51, 0x20, then the remaining 9 card bytes -> one frame_error, then a commit with remote_deal=1 and remote_dealer_finished=0.
- Reset mid-frame: rst pulsed after 5 bytes of a frame -> all outputs 0 and HUNT. The remaining bytes cause no commit; the next clean frame commits.
